asrv32_memoryaccess: RTL and testbench
======================================

Name: asrv32_memoryaccess

Overview:
Stage 4 [MEMORYACCESS] of the ASRV32 5-stage pipeline.
- Consumes the registered ALU-stage result: address/rd value, store data, rd controls.
- Runs the data-memory bus cycle for LOAD/STORE: pipelined Wishbone, single outstanding request.
- Registers rd address, rd write-enable and rd value towards stage 5 [WRITEBACK]; these feed the operand-forwarding logic as the stage-5 forwarding source.
- Raises a stall towards earlier stages while a bus cycle is pending.

Parameters:
ADDR_WIDTH, 32, width of the data-memory byte address.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_ce  in  1  stage enable from ALU stage (valid instruction present)
i_stall  in  1  stall request from writeback stage
i_flush  in  1  flush request from writeback stage (trap/branch)
i_rs2  in  32  store data (forwarded rs2)
i_y  in  32  ALU result: effective address for LOAD/STORE, rd value otherwise
i_funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; SB/SH/SW use 000/001/010
i_opcode_load  in  1  instruction is LOAD
i_opcode_store  in  1  instruction is STORE
i_rd_addr  in  5  destination register
i_wr_rd  in  1  instruction writes rd
o_rd_addr  out  5  registered rd address to stage 5
o_wr_rd  out  1  registered rd write-enable to stage 5
o_rd  out  32  registered rd value: load data (extended) or i_y
o_ce  out  1  writeback stage enable
o_stall  out  1  stall to ALU stage and upstream
o_wb_cyc  out  1  bus cycle
o_wb_stb  out  1  bus strobe
o_wb_we  out  1  write enable
o_wb_addr  out  ADDR_WIDTH  word-aligned address (i_y with [1:0] cleared)
o_wb_data  out  32  lane-replicated store data
o_wb_sel  out  4  byte lane select
i_wb_ack  in  1  bus acknowledge
i_wb_stall  in  1  bus not accepting strobe
i_wb_data  in  32  load read data

Behaviour:
- Reset (i_rst_n low, async): all outputs 0; FSM to IDLE.
- FSM states and transitions:
  - IDLE -> REQ on (i_ce && (load || store) && !o_stall && !i_flush). Capture funct3, i_y[1:0], rd controls and bus fields on the transition.
  - REQ: o_wb_cyc=o_wb_stb=1. Stays while i_wb_stall. On !i_wb_stall -> WAIT, or -> IDLE directly if i_wb_ack is also high in that cycle.
  - WAIT: o_wb_cyc=1, o_wb_stb=0. -> IDLE on i_wb_ack.
- o_stall = i_stall || (state!=IDLE) || (state==IDLE && i_ce && (load||store) && !i_flush). It is the OR of the stall terms, so the ALU stage holds while the request is launched.
- Non-memory instruction (i_ce, no stall, no flush): next cycle o_ce=1, o_rd=i_y, o_rd_addr/o_wr_rd registered. Latency 1.
- STORE: o_ce pulses 1 the cycle after ack, with o_wr_rd=0.
- LOAD: o_ce pulses 1 the cycle after ack, with o_rd = extracted data. Minimum latency 2 cycles from acceptance (REQ, then ack in REQ).
- Store lanes by address offset:
  - SB: sel = 0001<<a[1:0], data = {4{rs2[7:0]}}.
  - SH: sel = a[1] ? 1100 : 0011, data = {2{rs2[15:0]}}.
  - SW: sel = 1111, data = rs2.
- Load extraction:
  - Byte is selected by a[1:0]; half by a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is the whole word.
- Misaligned accesses are trapped in the ALU stage; here, low address bits beyond lane selection are ignored.
- i_stall high, state IDLE: all stage-5 outputs hold, o_ce holds; no new request is launched.
- i_flush:
  - Next cycle o_ce=0.
  - A pending bus cycle runs to ack (cyc never dropped mid-cycle); its result is discarded and o_ce stays 0.
  - Flush has priority over a same-cycle i_ce.
- i_wb_ack while IDLE is ignored.
- Outside o_ce pulses, o_rd_addr/o_wr_rd/o_rd keep their last value. o_wr_rd is never qualified by anything other than o_ce downstream.
- Reset mid-transaction: bus lines drop immediately to 0.

Decomposition:
- Shared header asrv32_header.vh holds:
  - funct3 encodings: LB/LH/LW/LBU/LHU/SB/SH/SW.
  - FSM state encodings IDLE/REQ/WAIT.
- One sub-module is natural: asrv32_load_align. It is combinational: funct3 + addr[1:0] + raw word -> extended rd, and funct3 + addr + rs2 -> sel/data.

Test Plan:
- ADD result i_y=0x0000_1234, rd=5, i_ce=1 -> next cycle o_ce=1, o_rd=0x1234, o_rd_addr=5, o_wr_rd=1; no bus cycle.
- LB addr=0x103, bus returns 0x80FF_00AA with ack in REQ -> o_wb_addr=0x100, o_wb_sel=1111, o_rd=0xFFFF_FF80, o_ce one cycle after ack; o_stall high through the transaction.
- LHU addr=0x202, data 0xBEEF_0001, i_wb_stall high 3 cycles, ack 2 cycles later -> stb held 4 cycles, o_rd=0x0000_BEEF.
- SB addr=0x301, rs2=0x0000_00C5 -> o_wb_we=1, sel=0010, data=0xC5C5_C5C5; o_ce pulse with o_wr_rd=0.
- LW pending in WAIT, i_flush asserted, ack 2 cycles later -> cyc held until ack, o_ce stays 0, FSM returns to IDLE.
- i_stall high with valid i_ce LW -> no stb, outputs unchanged; release -> request launches next cycle.

Source files
------------

// File: rtl/asrv32_memoryaccess_pkg.sv
// ============================================================================
// asrv32_memoryaccess_pkg : shared funct3 encodings and FSM states of the
// ASRV32 memory-access stage.   Rev 1.0
// ============================================================================
`default_nettype none

package asrv32_memoryaccess_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

`default_nettype wire

// File: rtl/asrv32_load_align.sv
// ============================================================================
// asrv32_load_align : load-data extraction/extension and store lane steering.
// Rev 1.0
// ============================================================================
`default_nettype none

module asrv32_load_align
    import asrv32_memoryaccess_pkg::*;
(
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_word,
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_rs2,
    output logic [31:0] o_ld_rd,
    output logic [3:0]  o_st_sel,
    output logic [31:0] o_st_data
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shift = i_ld_word >> {i_ld_off, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        case (i_ld_funct3)
            F3_LB:   o_ld_rd = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_ld_rd = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_ld_rd = {24'd0, w_byte};
            F3_LHU:  o_ld_rd = {16'd0, w_half};
            default: o_ld_rd = i_ld_word;
        endcase
    end

    always_comb begin
        case (i_st_funct3)
            F3_SB: begin
                o_st_sel  = 4'b0001 << i_st_off;
                o_st_data = {4{i_st_rs2[7:0]}};
            end
            F3_SH: begin
                o_st_sel  = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_st_data = {2{i_st_rs2[15:0]}};
            end
            default: begin
                o_st_sel  = 4'b1111;
                o_st_data = i_st_rs2;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/asrv32_memoryaccess.sv
// ============================================================================
// asrv32_memoryaccess : ASRV32 stage 4, pipelined Wishbone data access with a
// single outstanding request and registered results towards writeback. Rev 1.0
// ============================================================================
`default_nettype none

module asrv32_memoryaccess
    import asrv32_memoryaccess_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ce,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [31:0]           i_rs2,
    input  logic [31:0]           i_y,
    input  logic [2:0]            i_funct3,
    input  logic                  i_opcode_load,
    input  logic                  i_opcode_store,
    input  logic [4:0]            i_rd_addr,
    input  logic                  i_wr_rd,
    output logic [4:0]            o_rd_addr,
    output logic                  o_wr_rd,
    output logic [31:0]           o_rd,
    output logic                  o_ce,
    output logic                  o_stall,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [31:0]           o_wb_data,
    output logic [3:0]            o_wb_sel,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic [31:0]           i_wb_data
);

    mem_state_t  r_state;
    mem_state_t  w_next;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_is_store;
    logic [4:0]  r_rd_addr;
    logic        r_wr_rd;
    logic        r_discard;

    logic        w_is_mem;
    logic        w_launch;
    logic        w_done;
    logic [31:0] w_ld_rd;
    logic [3:0]  w_st_sel;
    logic [31:0] w_st_data;

    assign w_is_mem = i_opcode_load | i_opcode_store;
    assign w_launch = (r_state == ST_IDLE) && i_ce && w_is_mem && !i_stall && !i_flush;
    assign w_done   = ((r_state == ST_REQ) && !i_wb_stall && i_wb_ack) ||
                      ((r_state == ST_WAIT) && i_wb_ack);

    assign o_wb_cyc = (r_state != ST_IDLE);
    assign o_wb_stb = (r_state == ST_REQ);
    // The launch term holds the ALU stage in the same cycle the request is captured.
    assign o_stall  = i_stall || (r_state != ST_IDLE) ||
                      (i_ce && w_is_mem && !i_flush);

    asrv32_load_align u_align (
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_off),
        .i_ld_word   (i_wb_data),
        .i_st_funct3 (i_funct3),
        .i_st_off    (i_y[1:0]),
        .i_st_rs2    (i_rs2),
        .o_ld_rd     (w_ld_rd),
        .o_st_sel    (w_st_sel),
        .o_st_data   (w_st_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_launch)    w_next = ST_REQ;
            ST_REQ:  if (!i_wb_stall) w_next = i_wb_ack ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (i_wb_ack)    w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_funct3   <= '0;
            r_off      <= '0;
            r_is_store <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_rd    <= 1'b0;
            r_discard  <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_addr  <= '0;
            o_wb_data  <= '0;
            o_wb_sel   <= '0;
            o_ce       <= 1'b0;
            o_rd       <= '0;
            o_rd_addr  <= '0;
            o_wr_rd    <= 1'b0;
        end else begin
            if (w_launch) begin
                r_funct3   <= i_funct3;
                r_off      <= i_y[1:0];
                r_is_store <= i_opcode_store;
                r_rd_addr  <= i_rd_addr;
                r_wr_rd    <= i_wr_rd && !i_opcode_store;
                r_discard  <= 1'b0;
                o_wb_we    <= i_opcode_store;
                o_wb_addr  <= {i_y[ADDR_WIDTH-1:2], 2'b00};
                o_wb_data  <= i_opcode_store ? w_st_data : 32'd0;
                o_wb_sel   <= i_opcode_store ? w_st_sel : 4'b1111;
            end
            // A flushed bus cycle still completes on the bus; only its result is dropped.
            if (i_flush && (r_state != ST_IDLE) && !w_done)
                r_discard <= 1'b1;

            if (i_flush) begin
                o_ce <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                if (!i_stall) begin
                    o_ce <= i_ce && !w_is_mem;
                    if (i_ce && !w_is_mem) begin
                        o_rd      <= i_y;
                        o_rd_addr <= i_rd_addr;
                        o_wr_rd   <= i_wr_rd;
                    end
                end
            end else if (w_done && !r_discard) begin
                o_ce      <= 1'b1;
                o_rd_addr <= r_rd_addr;
                o_wr_rd   <= r_wr_rd;
                if (!r_is_store)
                    o_rd <= w_ld_rd;
            end else begin
                o_ce <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_asrv32_memoryaccess.sv
// ============================================================================
// tb_asrv32_memoryaccess : randomized scoreboard bench for the memory stage.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_asrv32_memoryaccess;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_ce = 0, i_stall = 0, i_flush = 0;
    logic [31:0] i_rs2 = 0, i_y = 0;
    logic [2:0]  i_funct3 = 0;
    logic        i_opcode_load = 0, i_opcode_store = 0;
    logic [4:0]  i_rd_addr = 0;
    logic        i_wr_rd = 0;
    logic        i_wb_ack = 0, i_wb_stall = 0;
    logic [31:0] i_wb_data = 0;

    logic [4:0]  o_rd_addr;
    logic        o_wr_rd, o_ce, o_stall, o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_rd, o_wb_addr, o_wb_data;
    logic [3:0]  o_wb_sel;

    always #5 clk = ~clk;

    asrv32_memoryaccess #(.ADDR_WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(i_ce), .i_stall(i_stall),
        .i_flush(i_flush), .i_rs2(i_rs2), .i_y(i_y), .i_funct3(i_funct3),
        .i_opcode_load(i_opcode_load), .i_opcode_store(i_opcode_store),
        .i_rd_addr(i_rd_addr), .i_wr_rd(i_wr_rd),
        .o_rd_addr(o_rd_addr), .o_wr_rd(o_wr_rd), .o_rd(o_rd), .o_ce(o_ce),
        .o_stall(o_stall), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
        .i_wb_data(i_wb_data)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic        w;
        logic [31:0] d;
    } wb_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] data;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    int       n_cmp = 0;
    int       n_fail = 0;
    logic [31:0] last_rd = 0;
    logic     stall_edge = 1'b0;

    always @(posedge clk) stall_edge <= i_stall;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: memory semantics expressed with whole-word arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
            3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    function automatic bus_exp_t ref_bus(input bit st, input logic [2:0] f3,
                                         input logic [31:0] y, input logic [31:0] rs2);
        bus_exp_t e;
        e.addr = y - (y % 4);
        e.we   = st;
        if (!st) begin
            e.sel = 4'hF;
            e.data = 0;
        end else if (f3 == 3'b000) begin
            e.sel  = 4'(1 << (y % 4));
            e.data = (rs2 & 32'hFF) * 32'h0101_0101;
        end else if (f3 == 3'b001) begin
            e.sel  = 4'(3 << (2 * ((y % 4) / 2)));
            e.data = (rs2 & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e.sel  = 4'hF;
            e.data = rs2;
        end
        return e;
    endfunction

    // Monitor: compares every presented result and every accepted strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_ce && !stall_edge) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_ce", {31'd0, o_ce}, 32'd0);
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    chk("rd_addr", {27'd0, o_rd_addr}, {27'd0, e.a});
                    chk("wr_rd", {31'd0, o_wr_rd}, {31'd0, e.w});
                    chk("rd", o_rd, e.d);
                end
            end
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_stb", {31'd0, o_wb_stb}, 32'd0);
                end else begin
                    bus_exp_t b;
                    b = bus_q.pop_front();
                    chk("wb_addr", o_wb_addr, b.addr);
                    chk("wb_we", {31'd0, o_wb_we}, {31'd0, b.we});
                    chk("wb_sel", {28'd0, o_wb_sel}, {28'd0, b.sel});
                    chk("wb_data", o_wb_data, b.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nonmem(input logic [4:0] rd, input bit wr, input logic [31:0] y);
        i_ce = 1; i_opcode_load = 0; i_opcode_store = 0;
        i_y = y; i_rd_addr = rd; i_wr_rd = wr;
        wb_q.push_back('{a: rd, w: wr, d: y});
        last_rd = y;
        @(negedge clk);
        chk("stall_nonmem", {31'd0, o_stall}, 32'd0);
        step();
        i_ce = 0;
    endtask

    task automatic memop(input bit is_load, input logic [2:0] f3, input logic [31:0] y,
                         input logic [31:0] rs2, input logic [4:0] rd, input bit wr,
                         input int nstall, input int ackdly, input bit do_flush,
                         input logic [31:0] rdata);
        int dly;
        dly = (do_flush && ackdly < 2) ? 2 : ackdly;
        i_ce = 1; i_opcode_load = is_load; i_opcode_store = !is_load;
        i_funct3 = f3; i_y = y; i_rs2 = rs2; i_rd_addr = rd; i_wr_rd = wr;
        bus_q.push_back(ref_bus(!is_load, f3, y, rs2));
        if (!do_flush) begin
            if (is_load) last_rd = ref_load(f3, y[1:0], rdata);
            wb_q.push_back('{a: rd, w: is_load ? wr : 1'b0, d: last_rd});
        end
        @(negedge clk);
        chk("stall_launch", {31'd0, o_stall}, 32'd1);
        step();
        i_ce = 0; i_opcode_load = 0; i_opcode_store = 0;
        i_wb_stall = (nstall > 0);
        for (int k = 0; k < nstall; k++) begin
            @(negedge clk);
            chk("stb_held", {30'd0, o_wb_cyc, o_wb_stb}, 32'd3);
            step();
        end
        i_wb_stall = 0;
        if (dly == 0) begin
            i_wb_ack = 1;
            i_wb_data = rdata;
        end
        @(negedge clk);
        chk("stall_busy", {31'd0, o_stall}, 32'd1);
        step();
        i_wb_ack = 0;
        if (dly > 0) begin
            for (int k = 1; k < dly; k++) begin
                i_flush = do_flush && (k == 1);
                @(negedge clk);
                chk("wait_cyc", {30'd0, o_wb_cyc, o_wb_stb}, 32'd2);
                step();
                i_flush = 0;
            end
            i_wb_ack = 1;
            i_wb_data = rdata;
            @(negedge clk);
            chk("wait_ack_cyc", {31'd0, o_wb_cyc}, 32'd1);
            step();
            i_wb_ack = 0;
        end
        i_wb_data = $urandom;
        @(negedge clk);
        chk("cyc_done", {31'd0, o_wb_cyc}, 32'd0);
        chk("stall_done", {31'd0, o_stall}, 32'd0);
        if (do_flush) chk("flush_ce", {31'd0, o_ce}, 32'd0);
        step();
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ce", {31'd0, o_ce}, 32'd0);
        chk("rst_rd", o_rd, 32'd0);
        chk("rst_bus", {28'd0, o_wb_cyc, o_wb_stb, o_wb_we, o_wr_rd}, 32'd0);
        chk("rst_addr", o_wb_addr, 32'd0);
        step();
        rst_n = 1;
        step();

        nonmem(5'd5, 1'b1, 32'h0000_1234);
        memop(1, 3'b000, 32'h103, 32'h0, 5'd7, 1, 0, 0, 0, 32'h80FF_00AA);
        memop(1, 3'b101, 32'h202, 32'h0, 5'd8, 1, 3, 2, 0, 32'hBEEF_0001);
        memop(0, 3'b000, 32'h301, 32'hC5, 5'd9, 1, 0, 1, 0, 32'h0);
        memop(1, 3'b010, 32'h400, 32'h0, 5'd10, 1, 0, 2, 1, 32'h1234_5678);

        // Flush wins over a same-cycle valid instruction.
        i_ce = 1; i_flush = 1; i_y = 32'hDEAD; i_rd_addr = 5'd3; i_wr_rd = 1;
        step();
        i_ce = 0; i_flush = 0;
        @(negedge clk);
        chk("flush_prio_ce", {31'd0, o_ce}, 32'd0);
        step();

        // Writeback stall: outputs hold, no request is launched.
        nonmem(5'd11, 1'b1, 32'hCAFE_0011);
        i_stall = 1;
        i_ce = 1; i_opcode_load = 1; i_funct3 = 3'b010; i_y = 32'h500;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_no_cyc", {31'd0, o_wb_cyc}, 32'd0);
            chk("stall_hold_ce", {31'd0, o_ce}, 32'd1);
            chk("stall_hold_rd", o_rd, last_rd);
            step();
        end
        i_stall = 0;
        memop(1, 3'b010, 32'h500, 32'h0, 5'd12, 1, 0, 0, 0, 32'h0BAD_F00D);

        for (int it = 0; it < 40; it++) begin
            int kind;
            logic [31:0] y;
            kind = $urandom_range(0, 2);
            y = $urandom;
            if (kind == 0)
                nonmem(5'($urandom), 1'($urandom), y);
            else if (kind == 1)
                memop(1, ld_f3[$urandom_range(0, 4)], y, 32'h0, 5'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                      $urandom);
            else
                memop(0, 3'($urandom_range(0, 2)), y, $urandom, 5'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), 0, 32'h0);
        end

        // Reset in the middle of a stalled request drops the bus at once.
        i_ce = 1; i_opcode_load = 1; i_funct3 = 3'b010; i_y = 32'h600; i_wb_stall = 1;
        step();
        i_ce = 0; i_opcode_load = 0;
        @(negedge clk);
        chk("mid_cyc", {31'd0, o_wb_cyc}, 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_bus", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
        chk("mid_rst_ce", {31'd0, o_ce}, 32'd0);
        step();
        i_wb_stall = 0;
        rst_n = 1;
        step();

        chk("wb_q_empty", wb_q.size(), 32'd0);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
